parity_word_rx: RTL and testbench

PARITY_WORD_RX -- requirements
Module: parity_word_rx

---
 rtl/parity_pkg.sv | 20 ++
 rtl/parity_word_rx.sv | 86 ++++++++
 tb/tb_parity_word_rx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity word receiver and its matching generator:
// state encoding, byte width and the parity calculation both ends must agree on.
package parity_pkg;

   localparam int BYTE_W = 8;
   localparam int MAX_WORD_W = 512;
   localparam logic [7:0] ERR_MAX = 8'hFF;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } rx_state_e;

   // Zero padding a narrower word up to MAX_WORD_W leaves the XOR unchanged.
   function automatic logic calcParity(input logic [MAX_WORD_W-1:0] data,
                                       input logic oddParity);
      return (^data) ^ oddParity;
   endfunction

endpackage

// File: rtl/parity_word_rx.sv
// Assembles NUM_BYTES little-endian byte beats into one word, checks its parity
// bit on the last beat and holds the result until downstream takes it.
module parity_word_rx
   import parity_pkg::*;
#(
   parameter int NUM_BYTES  = 8,
   parameter int ODD_PARITY = 0
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [BYTE_W-1:0]           byte_in,
   input  logic                        parity_in,
   input  logic                        byte_valid,
   output logic                        byte_ready,
   output logic [BYTE_W*NUM_BYTES-1:0] word_data,
   output logic                        parity_err,
   output logic                        word_valid,
   input  logic                        word_ready,
   output logic [7:0]                  err_count
);

   localparam int WORD_W = BYTE_W * NUM_BYTES;
   localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
   localparam logic ODD_SEL = (ODD_PARITY != 0);

   rx_state_e         state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              perr_q, perr_d;
   logic [7:0]        errCnt_q, errCnt_d;
   logic              beatAccept;
   logic              wordAccept;

   // The parity check sees the word including the byte arriving on this beat.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      word_d     = word_q;
      perr_d     = perr_q;
      errCnt_d   = errCnt_q;
      beatAccept = (state_q == COLLECT) && byte_valid;
      wordAccept = (state_q == HOLD) && word_ready;

      if (beatAccept) begin
         word_d[idx_q*BYTE_W +: BYTE_W] = byte_in;
         if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            perr_d  = calcParity(MAX_WORD_W'(word_d), ODD_SEL) != parity_in;
            state_d = HOLD;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end

      if (wordAccept) begin
         state_d = COLLECT;
         if (perr_q && (errCnt_q != ERR_MAX)) begin
            errCnt_d = errCnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= COLLECT;
         idx_q    <= '0;
         word_q   <= '0;
         perr_q   <= 1'b0;
         errCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         word_q   <= word_d;
         perr_q   <= perr_d;
         errCnt_q <= errCnt_d;
      end
   end

   assign byte_ready = (state_q == COLLECT);
   assign word_valid = (state_q == HOLD);
   assign word_data  = word_q;
   assign parity_err = perr_q;
   assign err_count  = errCnt_q;

endmodule

// File: tb/tb_parity_word_rx.sv
// Randomized self-checking bench: an even-parity and an odd-parity receiver
// share the same stimulus and are compared against a word-level reference model.
module tb_parity_word_rx;

   logic        clock;
   logic        reset;
   logic [7:0]  byte_in;
   logic        parity_in;
   logic        byte_valid;
   logic        word_ready;

   logic        byteReadyE, wordValidE, parityErrE;
   logic [63:0] wordDataE;
   logic [7:0]  errCountE;
   logic        byteReadyO, wordValidO, parityErrO;
   logic [63:0] wordDataO;
   logic [7:0]  errCountO;

   int testsRun;
   int testsFailed;
   int errModelE;
   int errModelO;
   bit expPerrE;
   bit expPerrO;

   parity_word_rx #(.NUM_BYTES(8), .ODD_PARITY(0)) dutE (
      .clock(clock), .reset(reset), .byte_in(byte_in), .parity_in(parity_in),
      .byte_valid(byte_valid), .byte_ready(byteReadyE), .word_data(wordDataE),
      .parity_err(parityErrE), .word_valid(wordValidE), .word_ready(word_ready),
      .err_count(errCountE)
   );

   parity_word_rx #(.NUM_BYTES(8), .ODD_PARITY(1)) dutO (
      .clock(clock), .reset(reset), .byte_in(byte_in), .parity_in(parity_in),
      .byte_valid(byte_valid), .byte_ready(byteReadyO), .word_data(wordDataO),
      .parity_err(parityErrO), .word_valid(wordValidO), .word_ready(word_ready),
      .err_count(errCountO)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout observed=running required=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   // Reference rule: even parity bit = 1 when the word has an odd number of ones.
   function automatic bit modelErr(input logic [63:0] w, input bit odd, input bit par);
      bit parityBit;
      parityBit = (($countones(w) % 2) == 1) ^ odd;
      return parityBit != par;
   endfunction

   function automatic int satInc(input int count);
      return (count >= 255) ? 255 : count + 1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s observed=%0h required=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitByteReady();
      int budget = 0;
      while (!(byteReadyE && byteReadyO) && budget < 20) begin
         @(negedge clock);
         budget++;
      end
      if (budget == 20) checkOutput("byte_ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic doReset();
      @(negedge clock);
      reset      = 1'b1;
      byte_valid = 1'b1;
      word_ready = 1'b1;
      byte_in    = 8'hA5;
      @(posedge clock);
      #1;
      reset      = 1'b0;
      byte_valid = 1'b0;
      word_ready = 1'b0;
      errModelE  = 0;
      errModelO  = 0;
      checkOutput("reset_byte_ready", {62'd0, byteReadyO, byteReadyE}, 64'd3);
      checkOutput("reset_word_valid", {62'd0, wordValidO, wordValidE}, 64'd0);
      checkOutput("reset_word_data", wordDataE | wordDataO, 64'd0);
      checkOutput("reset_parity_err", {62'd0, parityErrO, parityErrE}, 64'd0);
      checkOutput("reset_err_count", {48'd0, errCountO, errCountE}, 64'd0);
   endtask

   // Sends one full word beat by beat; random parity_in on non-final beats must be ignored.
   task automatic applyStimulus(input logic [63:0] word, input bit par, input bit gaps);
      for (int k = 0; k < 8; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               @(negedge clock);
               byte_valid = 1'b0;
               byte_in    = 8'($urandom);
            end
         end
         @(negedge clock);
         waitByteReady();
         byte_in    = 8'((word >> (8 * k)) & 64'hFF);
         parity_in  = (k == 7) ? par : 1'($urandom);
         byte_valid = 1'b1;
         @(posedge clock);
      end
      #1;
      byte_valid = 1'b0;
      expPerrE = modelErr(word, 1'b0, par);
      expPerrO = modelErr(word, 1'b1, par);
      checkOutput("word_valid_latency", {62'd0, wordValidO, wordValidE}, 64'd3);
      checkOutput("byte_ready_in_hold", {62'd0, byteReadyO, byteReadyE}, 64'd0);
      checkOutput("word_data_even", wordDataE, word);
      checkOutput("word_data_odd", wordDataO, word);
      checkOutput("parity_err_even", {63'd0, parityErrE}, {63'd0, expPerrE});
      checkOutput("parity_err_odd", {63'd0, parityErrO}, {63'd0, expPerrO});
   endtask

   task automatic drainWord();
      @(negedge clock);
      word_ready = 1'b1;
      @(posedge clock);
      #1;
      word_ready = 1'b0;
      byte_valid = 1'b0;
      if (expPerrE) errModelE = satInc(errModelE);
      if (expPerrO) errModelO = satInc(errModelO);
      checkOutput("drain_word_valid", {62'd0, wordValidO, wordValidE}, 64'd0);
      checkOutput("drain_byte_ready", {62'd0, byteReadyO, byteReadyE}, 64'd3);
      checkOutput("err_count_even", {56'd0, errCountE}, 64'(errModelE));
      checkOutput("err_count_odd", {56'd0, errCountO}, 64'(errModelO));
   endtask

   initial begin
      logic [63:0] w;
      testsRun   = 0;
      testsFailed = 0;
      reset      = 1'b0;
      byte_in    = 8'd0;
      parity_in  = 1'b0;
      byte_valid = 1'b0;
      word_ready = 1'b0;
      errModelE  = 0;
      errModelO  = 0;
      repeat (2) @(posedge clock);
      doReset();

      // Word 32 with correct even parity, then with the wrong parity bit.
      applyStimulus(64'd32, 1'b1, 1'b0);
      checkOutput("good_word_no_err", {63'd0, parityErrE}, 64'd0);
      drainWord();
      applyStimulus(64'd32, 1'b0, 1'b0);
      checkOutput("bad_word_err", {63'd0, parityErrE}, 64'd1);
      drainWord();
      checkOutput("bad_word_count", {56'd0, errCountE}, 64'd1);

      // Downstream stalls while the source keeps offering beats.
      w = {$urandom, $urandom};
      applyStimulus(w, 1'($urandom), 1'b0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         byte_valid = 1'b1;
         byte_in    = 8'($urandom);
         @(posedge clock);
         #1;
         checkOutput("stall_byte_ready", {63'd0, byteReadyE}, 64'd0);
         checkOutput("stall_word_data", wordDataE, w);
      end
      drainWord();
      applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
      drainWord();

      // Partial word discarded by reset.
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         byte_in    = 8'hF0 + 8'(k);
         parity_in  = 1'b1;
         byte_valid = 1'b1;
      end
      doReset();
      w = {$urandom, $urandom};
      applyStimulus(w, 1'($urandom), 1'b0);
      drainWord();

      // Random words with random idle gaps between beats.
      for (int n = 0; n < 20; n++) begin
         w = {$urandom, $urandom};
         applyStimulus(w, 1'($urandom), 1'b1);
         drainWord();
      end

      // Saturate the even receiver's error counter.
      for (int n = 0; n < 260; n++) begin
         w = {$urandom, $urandom};
         applyStimulus(w, ~(($countones(w) % 2) == 1), 1'b0);
         drainWord();
      end
      checkOutput("err_count_saturated", {56'd0, errCountE}, 64'd255);

      // Odd parity on an all-zero word, back to back and with gaps.
      doReset();
      applyStimulus(64'd0, 1'b1, 1'b0);
      checkOutput("odd_zero_word", {63'd0, parityErrO}, 64'd0);
      drainWord();
      applyStimulus(64'd0, 1'b1, 1'b1);
      checkOutput("odd_zero_word_gaps", {63'd0, parityErrO}, 64'd0);
      drainWord();
      checkOutput("odd_err_count", {56'd0, errCountO}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
